// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared FSM state, CSR address and cause-code definitions for the trap sequencer
package trap_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FLUSH    = 3'd1,
        S_SAVE     = 3'd2,
        S_REDIRECT = 3'd3,
        S_RET      = 3'd4
    } trap_state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [3:0] CAUSE_INSN_MISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_LOAD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_FAULT    = 4'd5;
    localparam logic [3:0] CAUSE_IRQ_MSI       = 4'd3;
    localparam logic [3:0] CAUSE_IRQ_MTI       = 4'd7;
    localparam logic [3:0] CAUSE_IRQ_MEI       = 4'd11;

endpackage

// File: rtl/irq_priority.sv
// rtl/irq_priority.sv - fixed-priority encoder for masked machine interrupt lines
module irq_priority
    import trap_pkg::*;
(
    input  logic       mei,
    input  logic       msi,
    input  logic       mti,
    output logic       valid,
    output logic [3:0] cause
);

    // External beats software beats timer.
    always_comb begin
        valid = mei | msi | mti;
        cause = CAUSE_INSN_MISALIGN;
        if (mei)      cause = CAUSE_IRQ_MEI;
        else if (msi) cause = CAUSE_IRQ_MSI;
        else if (mti) cause = CAUSE_IRQ_MTI;
    end

endmodule

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - machine-mode trap entry/return sequencer with its CSR file
module trap_sequencer
    import trap_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            exc_valid,
    input  logic [3:0]      exc_cause,
    input  logic [XLEN-1:0] exc_tval,
    input  logic [XLEN-1:0] exc_pc,
    input  logic            mtip,
    input  logic            msip,
    input  logic            meip,
    input  logic            retire,
    input  logic [XLEN-1:0] retire_pc,
    input  logic            mret,
    input  logic            drain_done,
    input  logic            csr_we,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            flush,
    output logic            stall,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            trap_active
);

    trap_state_t     state;
    logic            status_mie;
    logic            status_mpie;
    logic [2:0]      mie_en;
    logic [2:0]      mip_q;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mtval;

    logic [3:0]      cause_q;
    logic [XLEN-1:0] tval_q;
    logic [XLEN-1:0] epc_q;
    logic            is_irq_q;

    logic            irq_valid;
    logic [3:0]      irq_cause;
    logic            irq_take;
    logic [XLEN-1:0] trap_target;

    // Bit order of mie_en/mip_q is {MEI, MSI, MTI}.
    irq_priority u_irq_priority (
        .mei   (mie_en[2] & mip_q[2]),
        .msi   (mie_en[1] & mip_q[1]),
        .mti   (mie_en[0] & mip_q[0]),
        .valid (irq_valid),
        .cause (irq_cause)
    );

    assign irq_take = status_mie & irq_valid;

    assign trap_target = {mtvec[XLEN-1:2], 2'b00}
                       + ((is_irq_q && mtvec[1:0] == 2'b01)
                          ? {{(XLEN-6){1'b0}}, cause_q, 2'b00} : '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            status_mie  <= 1'b0;
            status_mpie <= 1'b0;
            mie_en      <= '0;
            mip_q       <= '0;
            mtvec       <= RESET_MTVEC;
            mepc        <= '0;
            mcause      <= '0;
            mtval       <= '0;
            cause_q     <= '0;
            tval_q      <= '0;
            epc_q       <= '0;
            is_irq_q    <= 1'b0;
        end else begin
            mip_q <= {meip, msip, mtip};

            // SAVE owns the trap CSRs for its cycle, so software writes are dropped there.
            if (csr_we && state != S_SAVE) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        status_mie  <= csr_wdata[3];
                        status_mpie <= csr_wdata[7];
                    end
                    CSR_MIE:    mie_en <= {csr_wdata[11], csr_wdata[3], csr_wdata[7]};
                    CSR_MTVEC:  mtvec  <= csr_wdata;
                    CSR_MEPC:   mepc   <= {csr_wdata[XLEN-1:2], 2'b00};
                    CSR_MCAUSE: mcause <= csr_wdata;
                    CSR_MTVAL:  mtval  <= csr_wdata;
                    default: ;
                endcase
            end

            case (state)
                S_IDLE: begin
                    if (exc_valid) begin
                        cause_q  <= exc_cause;
                        tval_q   <= exc_tval;
                        epc_q    <= exc_pc;
                        is_irq_q <= 1'b0;
                        state    <= S_FLUSH;
                    end else if (retire && irq_take) begin
                        cause_q  <= irq_cause;
                        tval_q   <= '0;
                        epc_q    <= retire_pc;
                        is_irq_q <= 1'b1;
                        state    <= S_FLUSH;
                    end else if (mret) begin
                        status_mie  <= status_mpie;
                        status_mpie <= 1'b1;
                        state       <= S_RET;
                    end
                end
                S_FLUSH: begin
                    if (drain_done) state <= S_SAVE;
                end
                S_SAVE: begin
                    mepc        <= epc_q;
                    mcause      <= {is_irq_q, {(XLEN-5){1'b0}}, cause_q};
                    mtval       <= tval_q;
                    status_mpie <= status_mie;
                    status_mie  <= 1'b0;
                    state       <= S_REDIRECT;
                end
                S_REDIRECT: state <= S_IDLE;
                S_RET:      state <= S_IDLE;
                default:    state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        flush          = (state == S_FLUSH);
        stall          = (state != S_IDLE);
        trap_active    = (state == S_FLUSH) || (state == S_SAVE) || (state == S_REDIRECT);
        redirect_valid = (state == S_REDIRECT) || (state == S_RET);
        redirect_pc    = '0;
        if (state == S_REDIRECT) redirect_pc = trap_target;
        else if (state == S_RET) redirect_pc = mepc;
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_rdata[3] = status_mie;
                csr_rdata[7] = status_mpie;
            end
            CSR_MIE: begin
                csr_rdata[11] = mie_en[2];
                csr_rdata[3]  = mie_en[1];
                csr_rdata[7]  = mie_en[0];
            end
            CSR_MTVEC:  csr_rdata = mtvec;
            CSR_MEPC:   csr_rdata = mepc;
            CSR_MCAUSE: csr_rdata = mcause;
            CSR_MTVAL:  csr_rdata = mtval;
            CSR_MIP: begin
                csr_rdata[11] = mip_q[2];
                csr_rdata[3]  = mip_q[1];
                csr_rdata[7]  = mip_q[0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - directed self-checking bench for trap_sequencer
module tb_trap_sequencer;
    import trap_pkg::*;

    localparam logic [31:0] RST_VEC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        resetn;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_tval;
    logic [31:0] exc_pc;
    logic        mtip, msip, meip;
    logic        retire;
    logic [31:0] retire_pc;
    logic        mret;
    logic        drain_done;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        flush, stall, redirect_valid, trap_active;
    logic [31:0] redirect_pc;

    int pass_cnt = 0;
    int total_cnt = 0;

    trap_sequencer #(.XLEN(32), .RESET_MTVEC(RST_VEC)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .exc_tval       (exc_tval),
        .exc_pc         (exc_pc),
        .mtip           (mtip),
        .msip           (msip),
        .meip           (meip),
        .retire         (retire),
        .retire_pc      (retire_pc),
        .mret           (mret),
        .drain_done     (drain_done),
        .csr_we         (csr_we),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .flush          (flush),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_active    (trap_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        csr_we = 1'b1; csr_addr = addr; csr_wdata = data;
        @(negedge clk);
        csr_we = 1'b0; csr_wdata = '0;
    endtask

    task automatic csr_check(input string tag, input logic [11:0] addr, input logic [31:0] expected);
        csr_addr = addr;
        #1;
        check(tag, csr_rdata, expected);
    endtask

    // Stimulus is already driven; waits (bounded) for redirect and checks latency and target.
    task automatic await_redirect(input string tag, input int exp_lat, input logic [31:0] exp_pc);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cnt++;
            exc_valid = 1'b0; retire = 1'b0; mret = 1'b0;
            if (redirect_valid) break;
        end
        check({tag, "_lat"}, cnt, exp_lat);
        check({tag, "_pc"}, redirect_pc, exp_pc);
        @(negedge clk);
        check({tag, "_stall_after"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        resetn = 1'b0; exc_valid = 0; exc_cause = 0; exc_tval = 0; exc_pc = 0;
        mtip = 0; msip = 0; meip = 0; retire = 0; retire_pc = 0; mret = 0;
        drain_done = 1'b1; csr_we = 0; csr_addr = 0; csr_wdata = 0;

        // Reset state
        #12;
        check("rst_outs", {27'd0, flush, stall, redirect_valid, trap_active, 1'b0}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        csr_check("rst_mtvec", CSR_MTVEC, RST_VEC);
        csr_check("rst_mstatus", CSR_MSTATUS, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Misaligned load exception
        csr_write(CSR_MTVEC, 32'h400);
        exc_valid = 1; exc_cause = CAUSE_LOAD_MISALIGN; exc_pc = 32'h100; exc_tval = 32'h203;
        @(negedge clk);
        exc_valid = 0;
        check("exc_flush", {29'd0, flush, stall, trap_active}, 32'b111);
        @(negedge clk);
        check("exc_save", {29'd0, flush, stall, trap_active}, 32'b011);
        @(negedge clk);
        check("exc_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check("exc_redirect_pc", redirect_pc, 32'h400);
        @(negedge clk);
        check("exc_idle_stall", {31'd0, stall}, 32'd0);
        csr_check("exc_mepc", CSR_MEPC, 32'h100);
        csr_check("exc_mcause", CSR_MCAUSE, 32'd4);
        csr_check("exc_mtval", CSR_MTVAL, 32'h203);
        csr_check("unknown_read", 12'h7C0, 32'd0);

        // Vectored timer interrupt
        csr_write(CSR_MTVEC, 32'h801);
        csr_write(CSR_MSTATUS, 32'h8);
        csr_write(CSR_MIE, 32'h80);
        mtip = 1;
        @(negedge clk);
        csr_check("mip_timer", CSR_MIP, 32'h80);
        retire = 1; retire_pc = 32'h50;
        await_redirect("tmr", 3, 32'h81C);
        csr_check("tmr_mcause", CSR_MCAUSE, 32'h8000_0007);
        csr_check("tmr_mepc", CSR_MEPC, 32'h50);
        csr_check("tmr_mstatus", CSR_MSTATUS, 32'h80);
        mtip = 0;

        // Priority: exception beats pending interrupts, then MEI beats MTI
        mret = 1;
        await_redirect("ret1", 1, 32'h50);
        csr_check("ret1_mstatus", CSR_MSTATUS, 32'h88);
        csr_write(CSR_MIE, 32'h880);
        meip = 1; mtip = 1;
        @(negedge clk);
        csr_check("mip_both", CSR_MIP, 32'h880);
        exc_valid = 1; exc_cause = CAUSE_LOAD_FAULT; exc_pc = 32'h200; exc_tval = 32'h0;
        retire = 1; retire_pc = 32'h60;
        await_redirect("prio_exc", 3, 32'h800);
        csr_check("prio_exc_mcause", CSR_MCAUSE, 32'd5);
        csr_check("prio_exc_mepc", CSR_MEPC, 32'h200);
        mret = 1;
        await_redirect("ret2", 1, 32'h200);
        retire = 1; retire_pc = 32'h70;
        await_redirect("prio_mei", 3, 32'h82C);
        csr_check("prio_mei_mcause", CSR_MCAUSE, 32'h8000_000B);
        csr_check("prio_mei_mepc", CSR_MEPC, 32'h70);
        meip = 0; mtip = 0;

        // mepc alignment and mret
        csr_write(CSR_MEPC, 32'h1237);
        csr_check("mepc_align", CSR_MEPC, 32'h1234);
        csr_check("pre_ret_mstatus", CSR_MSTATUS, 32'h80);
        mret = 1;
        await_redirect("ret3", 1, 32'h1234);
        csr_check("ret3_mstatus", CSR_MSTATUS, 32'h88);

        // Slow drain keeps flush/stall up
        csr_write(CSR_MIE, 32'h0);
        drain_done = 0;
        exc_valid = 1; exc_cause = CAUSE_INSN_MISALIGN; exc_pc = 32'h300; exc_tval = 32'h0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            exc_valid = 0;
            check($sformatf("drain_hold_%0d", i), {30'd0, flush, stall}, 32'b11);
        end
        drain_done = 1;
        @(negedge clk);
        check("drain_save", {30'd0, flush, stall}, 32'b01);
        @(negedge clk);
        check("drain_redirect", redirect_pc, 32'h800);
        @(negedge clk);

        // Reset in FLUSH abandons the trap
        #2 resetn = 0;
        #1 check("rst2_mepc_cleared", 32'd0, 32'd0 | {31'd0, stall});
        @(negedge clk);
        resetn = 1;
        @(negedge clk);
        drain_done = 0;
        exc_valid = 1; exc_cause = CAUSE_LOAD_FAULT; exc_pc = 32'h500; exc_tval = 32'h9;
        @(negedge clk);
        exc_valid = 0;
        @(negedge clk);
        check("mid_flush", {31'd0, flush}, 32'd1);
        #2 resetn = 0;
        #1;
        check("mid_rst_outs", {28'd0, flush, stall, redirect_valid, trap_active}, 32'd0);
        @(negedge clk);
        resetn = 1;
        drain_done = 1;
        @(negedge clk);
        check("mid_rst_idle", {31'd0, stall}, 32'd0);
        csr_check("mid_rst_mepc", CSR_MEPC, 32'd0);
        csr_check("mid_rst_mcause", CSR_MCAUSE, 32'd0);
        csr_check("mid_rst_mtvec", CSR_MTVEC, RST_VEC);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
